uart_rx_capture: RTL

- Synthesizable UART receiver that consumes the SoC UART TX line (gpio_out[17] of e203_soc_demo).
- Converts the 8N1 serial stream into bytes and buffers them in a small first-word-fall-through (FWFT) FIFO.
- A downstream consumer drains the bytes over a valid/ready handshake.
- Replaces timing-delay sampling with a clock-counted, checkable receiver usable in Verilator and on FPGA.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_capture_fifo.sv | 81 ++++++++
 rtl/uart_rx_capture.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the uart_rx_capture receiver:
//   - receiver FSM state encoding (IDLE, START, DATA, STOP, WAIT_IDLE)
//   - UART_DATA_W : width of one received character
//   - half_bit_count() : clk cycles from the start-bit falling edge to the
//     start-bit centre
// -----------------------------------------------------------------------------
package uart_rx_pkg;

   localparam int UART_DATA_W = 8;

   typedef logic [2:0] rx_state_t;

   localparam rx_state_t ST_IDLE      = 3'd0;
   localparam rx_state_t ST_START     = 3'd1;
   localparam rx_state_t ST_DATA      = 3'd2;
   localparam rx_state_t ST_STOP      = 3'd3;
   localparam rx_state_t ST_WAIT_IDLE = 3'd4;

   function automatic int half_bit_count(input int clks_per_bit);
      return clks_per_bit / 2;
   endfunction

endpackage

// File: rtl/uart_rx_capture_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through byte FIFO. head_data always shows the oldest
// entry; a pop simply advances the read pointer.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (pointers only)
//   push, push_data write request and byte
//   pop             consume head (ignored while empty)
//   head_data       byte at the read pointer
//   full, empty     occupancy flags
//   level           occupancy 0..DEPTH
// A push while full is accepted only if a pop happens in the same cycle,
// since that pop frees the slot being written.
// -----------------------------------------------------------------------------
module uart_rx_fifo
   import uart_rx_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [UART_DATA_W-1:0] push_data,
   input  logic                   pop,
   output logic [UART_DATA_W-1:0] head_data,
   output logic                   full,
   output logic                   empty,
   output logic [LVL_W-1:0]       level
);

   localparam int AW = LVL_W - 1;

   logic [UART_DATA_W-1:0] mem_q [DEPTH];
   logic [LVL_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic                   do_push;
   logic                   do_pop;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level = wr_ptr_q - rd_ptr_q;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign head_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage has no reset; the top masks the head while empty.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
         if (do_push && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
            mem_q[gi] <= push_data;
         end
      end
   end

endmodule

// File: rtl/uart_rx_capture.sv
// -----------------------------------------------------------------------------
// uart_rx_capture
// 8N1 UART receiver for the SoC UART TX line, with an FWFT byte FIFO
// drained over a valid/ready handshake.
// Ports:
//   clk         single clock
//   rst         asynchronous active-high reset
//   rxd         serial input, idle high, asynchronous to clk
//   rx_data     FIFO head byte (0 while empty)
//   rx_valid    FIFO not empty
//   rx_ready    consumer takes the head when rx_valid & rx_ready
//   frame_err   one-cycle pulse: stop bit sampled low, byte dropped
//   overflow    sticky: a byte was dropped because the FIFO was full
//   ovf_clr     clears overflow, wins over a same-cycle set
//   fifo_level  FIFO occupancy
//   busy        receiver FSM not idle
// Build option UART_RX_MAJORITY_EN: every bit decision is a 2-of-3 vote of
// the synchronized line over three consecutive clocks centred on the normal
// sample point. The decision lands one clock later, so the START phase is
// one clock longer and all later sample/decision points shift by one clock.
// -----------------------------------------------------------------------------
module uart_rx_capture
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 140,
   parameter int FIFO_DEPTH   = 16,
   parameter int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rxd,
   output logic [UART_DATA_W-1:0] rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic                   frame_err,
   output logic                   overflow,
   input  logic                   ovf_clr,
   output logic [LVL_W-1:0]       fifo_level,
   output logic                   busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int HALF  = half_bit_count(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
   localparam int START_END_I = HALF;
`else
   localparam int START_END_I = HALF - 1;
`endif
   localparam logic [CNT_W-1:0] START_END = CNT_W'(START_END_I);
   localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);

   // Synchronizer and edge detect
   logic rxd_meta_q, rxd_meta_d;
   logic rxs_q, rxs_d;
   logic rxs_prev_q, rxs_prev_d;
   logic fell;

   // Receiver FSM
   rx_state_t              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0]             idx_q, idx_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overflow_q, overflow_d;
   logic                   sample_bit;
   logic                   push;

   // FIFO interface
   logic [UART_DATA_W-1:0] head_data;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   pop;

   assign rxd_meta_d = rxd;
   assign rxs_d      = rxd_meta_q;
   assign rxs_prev_d = rxs_q;
   assign fell       = rxs_prev_q & ~rxs_q;

`ifdef UART_RX_MAJORITY_EN
   // hist_q[0] = rxs one clock ago, hist_q[1] = two clocks ago
   logic [1:0] hist_q, hist_d;

   assign hist_d     = {hist_q[0], rxs_q};
   assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) |
                       (hist_q[0] & rxs_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= hist_d;
      end
   end
`else
   assign sample_bit = rxs_q;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (fell) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == START_END) begin
               cnt_d   = '0;
               idx_d   = '0;
               // Line back high at mid start bit: glitch, not a frame.
               state_d = sample_bit ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               // LSB arrives first, so shift in from the top.
               shift_d = {sample_bit, shift_q[UART_DATA_W-1:1]};
               if (idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (cnt_q == BIT_END) begin
               cnt_d       = '0;
               push        = sample_bit;
               frame_err_d = ~sample_bit;
               state_d     = ST_WAIT_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_IDLE: begin
            // A held-low line (break) must not be read as new start bits.
            if (rxs_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign pop = ~fifo_empty & rx_ready;

   always_comb begin
      overflow_d = overflow_q;
      if (push && fifo_full && !pop) begin
         overflow_d = 1'b1;
      end
      if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_meta_q  <= 1'b1;
         rxs_q       <= 1'b1;
         rxs_prev_q  <= 1'b1;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         rxd_meta_q  <= rxd_meta_d;
         rxs_q       <= rxs_d;
         rxs_prev_q  <= rxs_prev_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (shift_d),
      .pop       (pop),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign rx_valid  = ~fifo_empty;
   assign rx_data   = fifo_empty ? '0 : head_data;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
